// File: rtl/stego_message_extractor.sv
// stego_message_extractor
//   Recovers an LSB-embedded message from a stream of audio samples. The low
//   BITS_PER_SAMPLE bits of every valid sample are shifted into an 8-bit
//   window (MSB first). In HUNT the window is compared against SYNC_WORD after
//   every sample; once found, the next byte is the payload length L, followed
//   by L payload bytes presented on a single-entry valid/ready output register.
//
//   Optional feature (macro STEGO_CHECKSUM_EN): a trailing checksum byte (XOR
//   of all payload bytes) is collected in state CHK and compared; it is never
//   forwarded. Without the macro, out_checksum_err is tied low.
//
// Ports:
//   in_clk, in_reset        clock / async active-high reset
//   in_sample[BPS]          received sample
//   in_sample_valid         sample strobe (always accepted)
//   in_byte_ready           downstream ready
//   out_byte[8]             recovered payload byte
//   out_byte_valid          out_byte valid, held until in_byte_ready
//   out_frame_start         1-cycle pulse on sync detection
//   out_frame_done          1-cycle pulse at end of frame
//   out_overrun             sticky: a payload byte was dropped
//   out_checksum_err        1-cycle pulse on checksum mismatch
module stego_message_extractor #(
    parameter int          BPS             = 16,
    parameter int          BITS_PER_SAMPLE = 1,
    parameter logic [7:0]  SYNC_WORD       = 8'hA5
) (
    input  logic           in_clk,
    input  logic           in_reset,
    input  logic [BPS-1:0] in_sample,
    input  logic           in_sample_valid,
    input  logic           in_byte_ready,
    output logic [7:0]     out_byte,
    output logic           out_byte_valid,
    output logic           out_frame_start,
    output logic           out_frame_done,
    output logic           out_overrun,
    output logic           out_checksum_err
);

    localparam int         SPB      = 8 / BITS_PER_SAMPLE;
    localparam logic [3:0] CNT_LAST = 4'(SPB - 1);

`ifdef STEGO_CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;
`else
    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;
`endif

    state_t     state;
    logic [7:0] shift;
    logic [7:0] shift_nxt;
    logic [3:0] cnt;
    logic [7:0] remaining;
    logic       byte_done;

    // Upper sample bits carry audio, not message data.
    logic unused_sample_bits;
    assign unused_sample_bits = ^in_sample[BPS-1:BITS_PER_SAMPLE];

    // Window after accepting the current sample's message bits.
    generate
        if (BITS_PER_SAMPLE == 8) begin : g_full
            assign shift_nxt = in_sample[7:0];
        end else begin : g_part
            assign shift_nxt = {shift[7-BITS_PER_SAMPLE:0], in_sample[BITS_PER_SAMPLE-1:0]};
        end
    endgenerate

    assign byte_done = in_sample_valid && (cnt == CNT_LAST);

`ifdef STEGO_CHECKSUM_EN
    logic [7:0] acc;
`else
    assign out_checksum_err = 1'b0;
`endif

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state           <= HUNT;
            shift           <= 8'h00;
            cnt             <= 4'd0;
            remaining       <= 8'd0;
            out_byte        <= 8'h00;
            out_byte_valid  <= 1'b0;
            out_frame_start <= 1'b0;
            out_frame_done  <= 1'b0;
            out_overrun     <= 1'b0;
`ifdef STEGO_CHECKSUM_EN
            acc              <= 8'h00;
            out_checksum_err <= 1'b0;
`endif
        end else begin
            out_frame_start <= 1'b0;
            out_frame_done  <= 1'b0;
`ifdef STEGO_CHECKSUM_EN
            out_checksum_err <= 1'b0;
`endif
            if (out_byte_valid && in_byte_ready)
                out_byte_valid <= 1'b0;

            if (in_sample_valid) begin
                shift <= shift_nxt;
                // Byte counter only matters once framed; HUNT aligns it at sync.
                if (state != HUNT)
                    cnt <= byte_done ? 4'd0 : cnt + 4'd1;

                case (state)
                    HUNT: begin
                        if (shift_nxt == SYNC_WORD) begin
                            out_frame_start <= 1'b1;
                            cnt             <= 4'd0;
                            state           <= LEN;
`ifdef STEGO_CHECKSUM_EN
                            acc             <= 8'h00;
`endif
                        end
                    end
                    LEN: begin
                        if (byte_done) begin
                            if (shift_nxt == 8'h00) begin
                                out_frame_done <= 1'b1;
                                state          <= HUNT;
                            end else begin
                                remaining <= shift_nxt;
                                state     <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (byte_done) begin
                            // A slot frees up when the held byte is taken this cycle.
                            if (!out_byte_valid || in_byte_ready) begin
                                out_byte       <= shift_nxt;
                                out_byte_valid <= 1'b1;
                            end else begin
                                out_overrun <= 1'b1;
                            end
                            remaining <= remaining - 8'd1;
`ifdef STEGO_CHECKSUM_EN
                            acc <= acc ^ shift_nxt;
                            if (remaining == 8'd1)
                                state <= CHK;
`else
                            if (remaining == 8'd1) begin
                                out_frame_done <= 1'b1;
                                state          <= HUNT;
                            end
`endif
                        end
                    end
`ifdef STEGO_CHECKSUM_EN
                    CHK: begin
                        if (byte_done) begin
                            out_frame_done   <= 1'b1;
                            out_checksum_err <= (shift_nxt != acc);
                            state            <= HUNT;
                        end
                    end
`endif
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stego_message_extractor.sv
module tb_stego_message_extractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s1 = '0, s4 = '0;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic        rdy1 = 1'b1, rdy4 = 1'b1;
    logic [7:0]  b1, b4;
    logic        bv1, fs1, fd1, ov1, ce1;
    logic        bv4, fs4, fd4, ov4, ce4;

    int tests = 0;
    int fails = 0;
    int st1 = 0, dn1 = 0;

    always #5 clk = ~clk;

    stego_message_extractor #(.BPS(16), .BITS_PER_SAMPLE(1), .SYNC_WORD(8'hA5)) dut1 (
        .in_clk(clk), .in_reset(rst), .in_sample(s1), .in_sample_valid(v1),
        .in_byte_ready(rdy1), .out_byte(b1), .out_byte_valid(bv1),
        .out_frame_start(fs1), .out_frame_done(fd1), .out_overrun(ov1),
        .out_checksum_err(ce1));

    stego_message_extractor #(.BPS(16), .BITS_PER_SAMPLE(4), .SYNC_WORD(8'hA5)) dut4 (
        .in_clk(clk), .in_reset(rst), .in_sample(s4), .in_sample_valid(v4),
        .in_byte_ready(rdy4), .out_byte(b4), .out_byte_valid(bv4),
        .out_frame_start(fs4), .out_frame_done(fd4), .out_overrun(ov4),
        .out_checksum_err(ce4));

    // Pulse counters for dut1.
    always @(negedge clk) begin
        if (fs1 === 1'b1) st1 <= st1 + 1;
        if (fd1 === 1'b1) dn1 <= dn1 + 1;
    end

    // One sample into dut1; returns #1 after the accepting edge.
    task automatic push1(input logic b);
        s1 = {15'($urandom), b};
        v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
    endtask

    task automatic byte1(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) push1(v[i]);
    endtask

    task automatic push4(input logic [3:0] n);
        s4 = {12'($urandom), n};
        v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
    endtask

    task automatic byte4(input logic [7:0] v);
        push4(v[7:4]);
        push4(v[3:0]);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if ({b1, bv1, fs1, fd1, ov1, ce1} !== 13'h0) begin
            fails++; $display("FAIL reset_dut1 got=%h exp=0", {b1, bv1, fs1, fd1, ov1, ce1});
        end
        tests++;
        if ({b4, bv4, fs4, fd4, ov4, ce4} !== 13'h0) begin
            fails++; $display("FAIL reset_dut4 got=%h exp=0", {b4, bv4, fs4, fd4, ov4, ce4});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int st0;
        st0 = st1;
        rdy1 = 1'b1;
        byte1(8'hA5);
        tests++;
        if (fs1 !== 1'b1) begin fails++; $display("FAIL basic_start got=%b exp=1", fs1); end
        push1(1'b0);
        tests++;
        if (fs1 !== 1'b0) begin fails++; $display("FAIL basic_start_width got=%b exp=0", fs1); end
        for (int i = 6; i >= 0; i--) push1(1'(8'h03 >> i));
        byte1(8'h48);
        tests++;
        if ({bv1, b1, fd1} !== {1'b1, 8'h48, 1'b0}) begin
            fails++; $display("FAIL basic_byte0 got=%b/%h/%b exp=1/48/0", bv1, b1, fd1);
        end
        push1(1'b0);
        tests++;
        if (bv1 !== 1'b0) begin fails++; $display("FAIL basic_valid_clear got=%b exp=0", bv1); end
        for (int i = 6; i >= 0; i--) push1(1'(8'h69 >> i));
        tests++;
        if ({bv1, b1} !== {1'b1, 8'h69}) begin
            fails++; $display("FAIL basic_byte1 got=%b/%h exp=1/69", bv1, b1);
        end
        byte1(8'h21);
        tests++;
        if ({bv1, b1, fd1, ce1} !== {1'b1, 8'h21, 1'b1, 1'b0}) begin
            fails++; $display("FAIL basic_last got=%b/%h/%b/%b exp=1/21/1/0", bv1, b1, fd1, ce1);
        end
        tick();
        tests++;
        if ({bv1, fd1, ov1} !== 3'b000) begin
            fails++; $display("FAIL basic_after got=%b exp=000", {bv1, fd1, ov1});
        end
        tests++;
        if (st1 - st0 !== 1) begin fails++; $display("FAIL basic_start_count got=%0d exp=1", st1 - st0); end
    endtask

    task automatic test_sync_search();
        int bad;
        logic [15:0] pat;
        pat = 16'hFFA5;
        bad = 0;
        for (int i = 15; i >= 1; i--) begin
            push1(pat[i]);
            if (fs1 !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL sync_early got=%0d pulses exp=0", bad); end
        push1(pat[0]);
        tests++;
        if (fs1 !== 1'b1) begin fails++; $display("FAIL sync_on_8th got=%b exp=1", fs1); end
        byte1(8'h00);
        tests++;
        if ({fd1, bv1} !== 2'b10) begin
            fails++; $display("FAIL sync_len0 got=%b exp=10", {fd1, bv1});
        end
    endtask

    task automatic test_bps4();
        rdy4 = 1'b1;
        push4(4'hA);
        tests++;
        if (fs4 !== 1'b0) begin fails++; $display("FAIL bps4_early got=%b exp=0", fs4); end
        push4(4'h5);
        tests++;
        if (fs4 !== 1'b1) begin fails++; $display("FAIL bps4_start got=%b exp=1", fs4); end
        push4(4'h0);
        tests++;
        if ({fs4, fd4} !== 2'b00) begin fails++; $display("FAIL bps4_mid got=%b exp=00", {fs4, fd4}); end
        push4(4'h0);
        tests++;
        if ({fd4, bv4} !== 2'b10) begin fails++; $display("FAIL bps4_len0 got=%b exp=10", {fd4, bv4}); end
        byte4(8'hA5); byte4(8'h01); byte4(8'hC3);
        tests++;
        if ({bv4, b4, fd4} !== {1'b1, 8'hC3, 1'b1}) begin
            fails++; $display("FAIL bps4_byte got=%b/%h/%b exp=1/c3/1", bv4, b4, fd4);
        end
    endtask

    task automatic test_overrun();
        rdy1 = 1'b0;
        byte1(8'hA5); byte1(8'h02); byte1(8'h11);
        tests++;
        if ({bv1, b1, ov1} !== {1'b1, 8'h11, 1'b0}) begin
            fails++; $display("FAIL ovr_first got=%b/%h/%b exp=1/11/0", bv1, b1, ov1);
        end
        byte1(8'h22);
        tests++;
        if ({bv1, b1, ov1, fd1} !== {1'b1, 8'h11, 1'b1, 1'b1}) begin
            fails++; $display("FAIL ovr_drop got=%b/%h/%b/%b exp=1/11/1/1", bv1, b1, ov1, fd1);
        end
        rdy1 = 1'b1;
        tick();
        tests++;
        if ({bv1, ov1} !== 2'b01) begin
            fails++; $display("FAIL ovr_sticky got=%b exp=01", {bv1, ov1});
        end
    endtask

    task automatic test_reset_midframe();
        int dn0, st0;
        rdy1 = 1'b1;
        byte1(8'hA5); byte1(8'h03); byte1(8'hAA);
        tests++;
        if ({bv1, b1} !== {1'b1, 8'hAA}) begin
            fails++; $display("FAIL rst_pre got=%b/%h exp=1/aa", bv1, b1);
        end
        push1(1'b1); push1(1'b0); push1(1'b1);
        dn0 = dn1;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({b1, bv1, fs1, fd1, ov1, ce1} !== 13'h0) begin
            fails++; $display("FAIL rst_async got=%h exp=0", {b1, bv1, fs1, fd1, ov1, ce1});
        end
        tick();
        rst = 1'b0;
        tick(); tick();
        tests++;
        if (dn1 !== dn0) begin fails++; $display("FAIL rst_no_done got=%0d exp=%0d", dn1, dn0); end
        st0 = st1;
        byte1(8'hA5); byte1(8'h01); byte1(8'h7E);
        tests++;
        if ({bv1, b1, fd1, ov1} !== {1'b1, 8'h7E, 1'b1, 1'b0}) begin
            fails++; $display("FAIL rst_recover got=%b/%h/%b/%b exp=1/7e/1/0", bv1, b1, fd1, ov1);
        end
        tests++;
        if (st1 - st0 !== 1) begin fails++; $display("FAIL rst_start_count got=%0d exp=1", st1 - st0); end
    endtask

`ifdef STEGO_CHECKSUM_EN
    task automatic test_checksum();
        rdy1 = 1'b1;
        byte1(8'hA5); byte1(8'h02); byte1(8'h0F); byte1(8'hF0);
        tests++;
        if ({bv1, b1, fd1} !== {1'b1, 8'hF0, 1'b0}) begin
            fails++; $display("FAIL chk_last_payload got=%b/%h/%b exp=1/f0/0", bv1, b1, fd1);
        end
        byte1(8'hFF);
        tests++;
        if ({fd1, ce1, bv1, b1} !== {1'b1, 1'b0, 1'b0, 8'hF0}) begin
            fails++; $display("FAIL chk_good got=%b/%b/%b/%h exp=1/0/0/f0", fd1, ce1, bv1, b1);
        end
        byte1(8'hA5); byte1(8'h02); byte1(8'h0F); byte1(8'hF0); byte1(8'h00);
        tests++;
        if ({fd1, ce1, bv1, b1} !== {1'b1, 1'b1, 1'b0, 8'hF0}) begin
            fails++; $display("FAIL chk_bad got=%b/%b/%b/%h exp=1/1/0/f0", fd1, ce1, bv1, b1);
        end
        tick();
        tests++;
        if ({fd1, ce1} !== 2'b00) begin fails++; $display("FAIL chk_pulse got=%b exp=00", {fd1, ce1}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sync_search();
        test_bps4();
        test_overrun();
        test_reset_midframe();
`ifdef STEGO_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
